sensor_cond: RTL and testbench

Sensor conditioning stage that sits directly downstream of the A2D interface. It consumes the held 12-bit `curr`, `torque` and `batt` readings and the raw pedal cadence pulse. It produces exponentially averaged current and torque, a windowed cadence count, a not-pedaling flag and a low-battery flag, all for the assist/PID logic. Everything is free-running and strobe-driven; there is no handshake with the A2D side, because its holding registers are always valid.

---
 rtl/sensor_cond.sv | 120 ++++++++++++
 tb/tb_sensor_cond.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_cond.sv
// Sensor conditioning downstream of the A2D holding registers: strobed exponential
// averages of current and torque, windowed pedal-cadence count, and threshold flags.
module sensor_cond #(
  parameter int          SMPL_W      = 20,
  parameter logic [11:0] LOW_BATT    = 12'hA98,
  parameter logic [7:0]  NOT_PED_THR = 8'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  input  logic [11:0] batt,
  input  logic        cadence_raw,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic [7:0]  cadence,
  output logic        not_pedaling,
  output logic        batt_low
);

  logic [SMPL_W-1:0] smpl_cnt;
  logic              smpl;
  logic [13:0]       curr_acc;
  logic [15:0]       torq_acc;
  logic              sync1, sync2, sync3;
  logic              cad_rise;
  logic [7:0]        wnd_cnt;
  logic [7:0]        edge_cnt;
  logic [7:0]        edge_nxt;
  logic              wnd_end;

  assign smpl     = &smpl_cnt;
  assign cad_rise = sync2 & ~sync3;
  assign wnd_end  = smpl & (wnd_cnt == 8'hFF);

  // Free-running sample-strobe timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_cnt <= '0;
    end else begin
      smpl_cnt <= smpl_cnt + SMPL_W'(1);
    end
  end

  // Exponential averages; acc - acc/N + x never exceeds N*4095, so no overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curr_acc <= 14'd0;
      torq_acc <= 16'd0;
    end else if (smpl) begin
      curr_acc <= curr_acc - {2'b00, curr_acc[13:2]} + {2'b00, curr};
      torq_acc <= torq_acc - {4'b0000, torq_acc[15:4]} + {4'b0000, torque};
    end else begin
      curr_acc <= curr_acc;
      torq_acc <= torq_acc;
    end
  end

  assign avg_curr   = curr_acc[13:2];
  assign avg_torque = torq_acc[15:4];

  // Two-flop synchronizer plus one flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= cadence_raw;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // An edge landing on the window-end cycle belongs to the new window
  always_comb begin
    edge_nxt = edge_cnt;
    if (wnd_end) begin
      edge_nxt = {7'b0000000, cad_rise};
    end else if (cad_rise && (edge_cnt != 8'hFF)) begin
      edge_nxt = edge_cnt + 8'd1;
    end else begin
      edge_nxt = edge_cnt;
    end
  end

  // Window counter, latched cadence and its not-pedaling flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wnd_cnt      <= 8'd0;
      edge_cnt     <= 8'd0;
      cadence      <= 8'd0;
      not_pedaling <= 1'b1;
    end else begin
      edge_cnt <= edge_nxt;
      if (smpl) begin
        wnd_cnt <= wnd_cnt + 8'd1;
      end else begin
        wnd_cnt <= wnd_cnt;
      end
      if (wnd_end) begin
        cadence      <= edge_cnt;
        not_pedaling <= (edge_cnt < NOT_PED_THR);
      end else begin
        cadence      <= cadence;
        not_pedaling <= not_pedaling;
      end
    end
  end

  // Battery threshold, unsigned compare every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_low <= 1'b0;
    end else begin
      batt_low <= (batt < LOW_BATT);
    end
  end

endmodule

// File: tb/tb_sensor_cond.sv
// Bench for sensor_cond: directed vectors and randomized traffic against a cycle-indexed
// behavioural model of strobes, windows and edge arrival times.
module tb_sensor_cond;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] curr, torque, batt;
  logic        cadence_raw;
  logic [11:0] avg_curr, avg_torque;
  logic [7:0]  cadence;
  logic        not_pedaling, batt_low;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sensor_cond #(.SMPL_W(4), .LOW_BATT(12'hA98), .NOT_PED_THR(8'd2)) dut (
    .clk(clk), .rst_n(rst_n), .curr(curr), .torque(torque), .batt(batt),
    .cadence_raw(cadence_raw), .avg_curr(avg_curr), .avg_torque(avg_torque),
    .cadence(cadence), .not_pedaling(not_pedaling), .batt_low(batt_low)
  );

  always #5 clk = ~clk;

  // Reference model: cyc is the index of the next post-reset edge
  int cyc  = 0;
  int m_ca = 0;
  int m_ta = 0;
  int e_cad = 0;
  bit e_np  = 1'b1;
  bit e_bl  = 1'b0;
  int win_cnt [16];
  bit samp [65536];

  initial begin : model
    int w;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; m_ca = 0; m_ta = 0; e_cad = 0; e_np = 1'b1; e_bl = 1'b0;
        for (int i = 0; i < 16; i++) win_cnt[i] = 0;
      end else begin
        samp[cyc] = cadence_raw;
        // A rise sampled first at edge k-2 is counted at edge k
        if (cyc >= 2 && samp[cyc-2] && (cyc < 3 || !samp[cyc-3])) begin
          w = (cyc + 1) / 4096;
          if (w < 16) win_cnt[w]++;
        end
        if (cyc % 4096 == 4095) begin
          w = cyc / 4096;
          e_cad = (win_cnt[w] > 255) ? 255 : win_cnt[w];
          e_np  = (e_cad < 2);
        end
        if (cyc % 16 == 15) begin
          m_ca = m_ca - m_ca / 4 + int'(curr);
          m_ta = m_ta - m_ta / 16 + int'(torque);
        end
        e_bl = (batt < 12'hA98);
        cyc++;
      end
    end
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [39:0] pack_dut();
    return {6'd0, avg_curr, avg_torque, cadence, not_pedaling, batt_low};
  endfunction

  function automatic logic [39:0] pack_model();
    logic [11:0] ac, at;
    logic [7:0]  cd;
    ac = 12'(m_ca / 4);
    at = 12'(m_ta / 16);
    cd = 8'(e_cad);
    return {6'd0, ac, at, cd, e_np, e_bl};
  endfunction

  // Periodic full-output comparison against the model
  initial begin : periodic
    forever begin
      @(negedge clk);
      if (chk_en && rst_n === 1'b1 && (cyc % 8 == 0)) check("model", pack_dut(), pack_model());
    end
  end

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      n_chk++; n_fail++;
      $display("FAIL wait_cyc: got %0d expected %0d", cyc, target);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    cadence_raw = 1'b1;
    repeat (hi) @(negedge clk);
    cadence_raw = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rand_run(input int ncyc, input int maxrun);
    int left;
    left = 0;
    for (int i = 0; i < ncyc; i++) begin
      curr   = 12'($urandom);
      torque = 12'($urandom);
      batt   = ($urandom_range(0, 3) == 0) ? 12'(12'hA97 + 12'($urandom_range(0, 2))) : 12'($urandom);
      if (left == 0) begin
        cadence_raw = ~cadence_raw;
        left = $urandom_range(2, maxrun);
      end
      left--;
      @(negedge clk);
    end
  endtask

  typedef struct { logic [11:0] batt; logic exp_low; } bvec_t;
  bvec_t btbl [6];

  localparam logic [39:0] RST_VAL = {6'd0, 12'h000, 12'h000, 8'h00, 1'b1, 1'b0};

  initial begin : stim
    btbl[0] = '{12'hA98, 1'b0};
    btbl[1] = '{12'hA97, 1'b1};
    btbl[2] = '{12'hFFF, 1'b0};
    btbl[3] = '{12'h000, 1'b1};
    btbl[4] = '{12'hA99, 1'b0};
    btbl[5] = '{12'h001, 1'b1};

    rst_n = 1'b0; cadence_raw = 1'b0;
    curr = 12'h5A5; torque = 12'hFFF; batt = 12'h123;
    repeat (5) @(negedge clk);
    check("reset_hold", pack_dut(), RST_VAL);

    batt = 12'h000; curr = 12'h400; torque = 12'h800;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("batt_low_after_release", batt_low, 1'b1);
    batt = 12'hFFF;

    wait_cyc(15);
    check("avg_curr_pre_strobe", avg_curr, 12'h000);
    wait_cyc(16);
    check("avg_curr_s1", avg_curr, 12'h100);
    check("avg_torque_s1", avg_torque, 12'h080);
    wait_cyc(32);
    check("avg_curr_s2", avg_curr, 12'h1C0);
    check("avg_torque_s2", avg_torque, 12'h0F8);

    // Toggle inputs between strobes; averages must hold
    wait_cyc(33);
    repeat (7) begin curr = 12'($urandom); torque = 12'($urandom); @(negedge clk); end
    check("avg_curr_hold", avg_curr, 12'h1C0);
    check("avg_torque_hold", avg_torque, 12'h0F8);
    repeat (7) begin curr = 12'($urandom); torque = 12'($urandom); @(negedge clk); end
    curr = 12'h400; torque = 12'h800;

    wait_cyc(800);
    check("avg_curr_converged", avg_curr, 12'h400);
    curr = 12'h000;
    wait_cyc(816);
    check("avg_curr_step", avg_curr, 12'h300);

    for (int i = 0; i < 6; i++) begin
      batt = btbl[i].batt;
      @(negedge clk);
      check("batt_tbl", batt_low, btbl[i].exp_low);
    end
    batt = 12'hFFF;

    wait_cyc(900);
    repeat (10) pulse(4, 4);
    wait_cyc(4096);
    check("cadence_w1", cadence, 8'd10);
    check("not_ped_w1", not_pedaling, 1'b0);

    wait_cyc(8192);
    check("cadence_w2", cadence, 8'd0);
    check("not_ped_w2", not_pedaling, 1'b1);

    wait_cyc(8300);
    pulse(2, 2);
    wait_cyc(12288);
    check("cadence_w3", cadence, 8'd1);
    check("not_ped_w3", not_pedaling, 1'b1);

    wait_cyc(12400);
    repeat (300) pulse(2, 2);
    wait_cyc(16384);
    check("cadence_sat", cadence, 8'd255);
    check("not_ped_sat", not_pedaling, 1'b0);

    // Three edges, then one rise that reaches the detector on the window-end edge
    wait_cyc(16500);
    repeat (3) pulse(3, 3);
    wait_cyc(20477);
    cadence_raw = 1'b1;
    wait_cyc(20480);
    check("cadence_boundary_excl", cadence, 8'd3);
    wait_cyc(20481);
    cadence_raw = 1'b0;
    wait_cyc(24576);
    check("cadence_boundary_incl", cadence, 8'd1);
    check("not_ped_boundary", not_pedaling, 1'b1);

    rand_run(1400, 8);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_window", pack_dut(), RST_VAL);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rand_run(4200, 30);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
